wb_trace_serializer: RTL and testbench
======================================

Name: wb_trace_serializer

Overview:
Producer side of the writeback-trace interface. Takes the CPU's two in-order writeback lanes (lane 0 older) and serializes their register writes into a single-issue debug_wb_* stream, one write per cycle, so a single-lane golden-trace comparator can consume it. Sits in the datapath next to the wb stage. Buffers dual-issue bursts, back-pressures the pipeline, and counts retired instructions.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 4
COUNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lane0_valid  in  1  lane 0 retires an instruction this cycle
lane0_wen  in  1  lane 0 writes the register file
lane0_rd  in  5  lane 0 destination register
lane0_wdata  in  32  lane 0 write data
lane0_pc  in  32  lane 0 instruction PC
lane1_valid / lane1_wen / lane1_rd / lane1_wdata / lane1_pc  in  1/1/5/32/32  same fields for lane 1 (younger)
stall_o  out  1  upstream must not retire this cycle
debug_wb_pc  out  32  PC of the emitted write
debug_wb_rf_wen  out  4  4'hf when a write is emitted, else 0
debug_wb_rf_wnum  out  5  emitted register number
debug_wb_rf_wdata  out  32  emitted data
retired_cnt  out  32  count of retired instructions
overflow_o  out  1  sticky: an entry was dropped

Behaviour:
- Reset is asynchronous and active-high. It immediately clears all outputs to 0, the FIFO occupancy count, and the read/write pointers.
- Push qualifier, per lane: valid && wen && rd != 0. Pushes are ordered lane 0, then lane 1. lane1 may push with lane0 idle.
- retired_cnt adds lane0_valid + lane1_valid on every edge, regardless of wen. It wraps modulo 2^32.
- Output register stage, updated every edge:
  - If count > 0: pop the FIFO head into the output registers. All of this cycle's pushes go to the FIFO tail.
  - If count == 0 and at least one push occurs: the oldest push bypasses straight to the output registers. The other push, if any, goes to the FIFO.
  - Otherwise: wen <= 0; pc, wnum and wdata hold their previous values.
- Latency: a lone write sampled at edge k is visible on the outputs after edge k. Each subsequent queued write follows one cycle later.
- stall_o is combinational from registered state: asserted when count >= DEPTH-1. When upstream honours it, net growth is at most +1 per cycle, so no drop occurs.
- Capacity rule: accepted pushes satisfy count - pop + accepted <= DEPTH.
  - Excess pushes are dropped, lane 1 first, and overflow_o is set.
  - overflow_o stays set until reset.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count updates as count + pushes_to_fifo - pop, in a single expression (no separate increment and decrement paths).
- Simultaneous pop and push when full: legal. The popped slot may be reused on the same edge.
- No output handshake: the consumer samples every cycle while wen != 0.

Decomposition:
- Package wb_trace_pkg:
  - trace_entry_t packed struct {pc[31:0], rd[4:0], wdata[31:0]}
  - constant WEN_ALL = 4'hf
- Sub-module wb_trace_fifo: 2-write/1-read circular buffer.
  - Inputs: push0, push1, entry0, entry1, pop.
  - Outputs: head, count.
  - Encapsulates the pointer and count arithmetic.
- The top level owns the push qualification, bypass, output register, counter and overflow logic.

Test Plan:
1. Single write: lane0 valid, wen=1, rd=2, wdata=0x1234, pc=0xbfc00000 at edge k -> after k: pc 0xbfc00000, wnum 2, wdata 0x1234, wen 4'hf. After k+1: wen 0, pc still 0xbfc00000. retired_cnt = 1.
2. Dual write: lane0 rd=3/0x11/pc 0xbfc00004 and lane1 rd=4/0x22/pc 0xbfc00008 in one cycle -> rd 3 emitted at k, rd 4 at k+1. retired_cnt += 2.
3. Filtering: lane0 valid with rd=0, and lane1 valid with wen=0 -> no emission (wen stays 0). retired_cnt += 2.
4. Burst, DEPTH=8: dual writes every cycle while honouring stall_o.
   - stall_o rises when count reaches 7.
   - All entries emerge in program order, one per cycle.
   - overflow_o stays 0.
5. Ignored stall: keep dual-pushing while stall_o = 1 -> lane 1 entries are dropped first, overflow_o = 1 and sticky. The surviving sequence has no reordering.
6. Reset mid-drain with count = 5: assert reset between edges -> all outputs and stall_o go to 0 immediately. After release, the first new write is emitted with 1-cycle latency.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback-trace serializer: one buffered register write.
package wb_trace_pkg;

    localparam logic [3:0] WEN_ALL = 4'hf;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular buffer accepting up to two writes and one read per cycle.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push0,
    input  logic               push1,
    input  trace_entry_t       entry0,
    input  trace_entry_t       entry1,
    input  logic               pop,
    output trace_entry_t       head,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] wptr1;

    // entry1 lands behind entry0 when both push, otherwise at the tail itself
    assign wptr1 = wptr + PTR_W'(push0);
    assign head  = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PTR_W'(pop);
            wptr  <= wptr + PTR_W'(push0) + PTR_W'(push1);
            count <= COUNT_W'(count + COUNT_W'(push0) + COUNT_W'(push1) - COUNT_W'(pop));
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem[wptr] <= entry0;
        if (push1) mem[wptr1] <= entry1;
    end

endmodule

// File: rtl/wb_trace_serializer.sv
// Serializes two in-order writeback lanes into a single debug_wb_* write stream.
module wb_trace_serializer
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lane0_valid,
    input  logic        lane0_wen,
    input  logic [4:0]  lane0_rd,
    input  logic [31:0] lane0_wdata,
    input  logic [31:0] lane0_pc,
    input  logic        lane1_valid,
    input  logic        lane1_wen,
    input  logic [4:0]  lane1_rd,
    input  logic [31:0] lane1_wdata,
    input  logic [31:0] lane1_pc,
    output logic        stall_o,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retired_cnt,
    output logic        overflow_o
);

    localparam logic [COUNT_W-1:0] FULL     = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] STALL_AT = COUNT_W'(DEPTH - 1);

    trace_entry_t       e0;
    trace_entry_t       e1;
    trace_entry_t       f_e0;
    trace_entry_t       f_e1;
    trace_entry_t       head;
    trace_entry_t       byp_entry;
    logic [COUNT_W-1:0] count;
    logic               p0;
    logic               p1;
    logic               pop;
    logic               f_push0;
    logic               f_push1;
    logic               bypass;
    logic               drop;

    assign e0  = '{pc: lane0_pc, rd: lane0_rd, wdata: lane0_wdata};
    assign e1  = '{pc: lane1_pc, rd: lane1_rd, wdata: lane1_wdata};
    assign p0  = lane0_valid & lane0_wen & (lane0_rd != 5'd0);
    assign p1  = lane1_valid & lane1_wen & (lane1_rd != 5'd0);
    assign pop = (count != '0);

    assign stall_o = (count >= STALL_AT);

    // Route pushes to bypass or FIFO; the pop frees a slot, so only lane 1 can be dropped
    always_comb begin
        f_push0   = 1'b0;
        f_push1   = 1'b0;
        f_e0      = e0;
        f_e1      = e1;
        bypass    = 1'b0;
        byp_entry = e0;
        drop      = 1'b0;
        if (pop) begin
            f_push0 = p0;
            f_push1 = p1 & ~(p0 & (count == FULL));
            drop    = p1 & p0 & (count == FULL);
        end else if (p0 | p1) begin
            bypass    = 1'b1;
            byp_entry = p0 ? e0 : e1;
            f_push0   = p0 & p1;
            f_e0      = e1;
        end
    end

    wb_trace_fifo #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push0  (f_push0),
        .push1  (f_push1),
        .entry0 (f_e0),
        .entry1 (f_e1),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
            retired_cnt       <= '0;
            overflow_o        <= 1'b0;
        end else begin
            retired_cnt <= retired_cnt + 32'(lane0_valid) + 32'(lane1_valid);
            if (drop) overflow_o <= 1'b1;
            if (pop) begin
                debug_wb_rf_wen   <= WEN_ALL;
                debug_wb_pc       <= head.pc;
                debug_wb_rf_wnum  <= head.rd;
                debug_wb_rf_wdata <= head.wdata;
            end else if (bypass) begin
                debug_wb_rf_wen   <= WEN_ALL;
                debug_wb_pc       <= byp_entry.pc;
                debug_wb_rf_wnum  <= byp_entry.rd;
                debug_wb_rf_wdata <= byp_entry.wdata;
            end else begin
                debug_wb_rf_wen <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Directed and randomized checks of wb_trace_serializer against a queue-based reference.
module tb_wb_trace_serializer;
    import wb_trace_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        lane0_valid, lane0_wen, lane1_valid, lane1_wen;
    logic [4:0]  lane0_rd, lane1_rd;
    logic [31:0] lane0_wdata, lane0_pc, lane1_wdata, lane1_pc;
    logic        stall_o, overflow_o;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata, retired_cnt;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    wb_trace_serializer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .lane0_valid       (lane0_valid),
        .lane0_wen         (lane0_wen),
        .lane0_rd          (lane0_rd),
        .lane0_wdata       (lane0_wdata),
        .lane0_pc          (lane0_pc),
        .lane1_valid       (lane1_valid),
        .lane1_wen         (lane1_wen),
        .lane1_rd          (lane1_rd),
        .lane1_wdata       (lane1_wdata),
        .lane1_pc          (lane1_pc),
        .stall_o           (stall_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retired_cnt       (retired_cnt),
        .overflow_o        (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference: queue of pending writes plus the last emitted write
    trace_entry_t q[$];
    logic [31:0]  m_pc, m_wdata, m_ret;
    logic [4:0]   m_wnum;
    logic         m_wen, m_ovf;
    logic [31:0]  pc_n;
    int           tests = 0;
    int           fails = 0;
    bit           saw_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = '0; m_wdata = '0; m_ret = '0; m_wnum = '0; m_wen = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic emit(input trace_entry_t e);
        m_wen = 1'b1; m_pc = e.pc; m_wnum = e.rd; m_wdata = e.wdata;
    endtask

    task automatic model_edge();
        trace_entry_t pl[$];
        if (lane0_valid && lane0_wen && lane0_rd != 5'd0)
            pl.push_back('{pc: lane0_pc, rd: lane0_rd, wdata: lane0_wdata});
        if (lane1_valid && lane1_wen && lane1_rd != 5'd0)
            pl.push_back('{pc: lane1_pc, rd: lane1_rd, wdata: lane1_wdata});
        m_ret = m_ret + 32'(lane0_valid) + 32'(lane1_valid);
        if (q.size() > 0) begin
            emit(q.pop_front());
            foreach (pl[i]) begin
                if (q.size() < DEPTH) q.push_back(pl[i]);
                else m_ovf = 1'b1;
            end
        end else if (pl.size() > 0) begin
            emit(pl[0]);
            for (int i = 1; i < pl.size(); i++) q.push_back(pl[i]);
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wen"},   32'(debug_wb_rf_wen), m_wen ? 32'hf : 32'h0);
        chk({tag, ".pc"},    debug_wb_pc, m_pc);
        chk({tag, ".wnum"},  32'(debug_wb_rf_wnum), 32'(m_wnum));
        chk({tag, ".wdata"}, debug_wb_rf_wdata, m_wdata);
        chk({tag, ".ret"},   retired_cnt, m_ret);
        chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
        chk({tag, ".stall"}, 32'(stall_o), (q.size() >= DEPTH - 1) ? 32'h1 : 32'h0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drv(input logic v0, input logic w0, input logic [4:0] r0,
                       input logic [31:0] d0, input logic [31:0] pc0,
                       input logic v1, input logic w1, input logic [4:0] r1,
                       input logic [31:0] d1, input logic [31:0] pc1);
        lane0_valid = v0; lane0_wen = w0; lane0_rd = r0; lane0_wdata = d0; lane0_pc = pc0;
        lane1_valid = v1; lane1_wen = w1; lane1_rd = r1; lane1_wdata = d1; lane1_pc = pc1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic dual_rand();
        drv(1'b1, 1'b1, 5'($urandom_range(1, 31)), 32'($urandom), pc_n,
            1'b1, 1'b1, 5'($urandom_range(1, 31)), 32'($urandom), pc_n + 32'd4);
        pc_n = pc_n + 32'd8;
    endtask

    task automatic mixed_rand(input bit honour);
        if (honour && q.size() >= DEPTH - 1) begin
            idle();
        end else begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                32'($urandom), pc_n,
                $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                32'($urandom), pc_n + 32'd4);
            pc_n = pc_n + 32'd8;
        end
    endtask

    initial begin
        pc_n = 32'hbfc01000;
        reset = 1'b1;
        idle();
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write: 1-cycle latency, then wen drops and pc holds
        drv(1'b1, 1'b1, 5'd2, 32'h1234, 32'hbfc00000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step("t1.emit");
        chk("t1.pc_const", debug_wb_pc, 32'hbfc00000);
        chk("t1.wnum_const", 32'(debug_wb_rf_wnum), 32'd2);
        chk("t1.ret_const", retired_cnt, 32'd1);
        idle();
        step("t1.after");
        chk("t1.wen_off", 32'(debug_wb_rf_wen), 32'h0);
        chk("t1.pc_hold", debug_wb_pc, 32'hbfc00000);

        // Dual write: lane 0 then lane 1 on consecutive cycles
        drv(1'b1, 1'b1, 5'd3, 32'h11, 32'hbfc00004, 1'b1, 1'b1, 5'd4, 32'h22, 32'hbfc00008);
        step("t2.k");
        chk("t2.wnum_k", 32'(debug_wb_rf_wnum), 32'd3);
        chk("t2.ret", retired_cnt, 32'd3);
        idle();
        step("t2.k1");
        chk("t2.wnum_k1", 32'(debug_wb_rf_wnum), 32'd4);
        chk("t2.wdata_k1", debug_wb_rf_wdata, 32'h22);
        step("t2.drain");

        // Filtering: rd=0 and wen=0 retire without emitting
        drv(1'b1, 1'b1, 5'd0, 32'h55, 32'hbfc0000c, 1'b1, 1'b0, 5'd5, 32'h66, 32'hbfc00010);
        step("t3");
        chk("t3.wen_off", 32'(debug_wb_rf_wen), 32'h0);
        chk("t3.ret", retired_cnt, 32'd5);

        // Burst honouring stall
        saw_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (q.size() >= DEPTH - 1) idle(); else dual_rand();
            step("t4.burst");
            if (stall_o) saw_stall = 1'b1;
        end
        chk("t4.saw_stall", 32'(saw_stall), 32'h1);
        idle();
        repeat (10) step("t4.drain");
        chk("t4.no_ovf", 32'(overflow_o), 32'h0);

        // Ignoring stall drops lane 1 and sets sticky overflow
        for (int i = 0; i < 16; i++) begin
            dual_rand();
            step("t5.flood");
        end
        chk("t5.ovf", 32'(overflow_o), 32'h1);
        idle();
        repeat (10) step("t5.drain");
        chk("t5.ovf_sticky", 32'(overflow_o), 32'h1);

        // Randomized mix, mostly honouring stall
        for (int i = 0; i < 300; i++) begin
            mixed_rand($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Reset mid-drain with five entries queued
        idle();
        step("t6.pre");
        #2;
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dual_rand();
            step("t6.fill");
        end
        idle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("t6.rst");
        chk("t6.stall_low", 32'(stall_o), 32'h0);
        #2;
        reset = 1'b0;
        drv(1'b1, 1'b1, 5'd7, 32'hcafe0001, 32'hbfc00100, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        step("t6.first");
        chk("t6.wnum_const", 32'(debug_wb_rf_wnum), 32'd7);
        chk("t6.ret_const", retired_cnt, 32'd1);
        idle();
        step("t6.after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
